// File: rtl/xbar_pkg.sv
// Shared constants and helpers for the 4x4 crossbar scheduler.
// Matrix bit order everywhere is in*N+out.
package xbar_pkg;

  localparam int N     = 4;
  localparam int LEN_W = 4;

  function automatic int idx(input int in_i, input int out_i);
    return in_i * N + out_i;
  endfunction

  // True for zero or exactly one bit set.
  function automatic logic onehot_ok(input logic [N-1:0] v);
    return (v & (v - N'(1))) == '0;
  endfunction

endpackage

// File: rtl/xbar_sched_conn_slot.sv
// One input row: holds the crossbar connection and the flit count
// of the packet in flight from this row.
module conn_slot
  import xbar_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       grant_row,
  input  logic [N*LEN_W-1:0] len_row,
  input  logic [N-1:0]       out_ready,
  output logic [N-1:0]       sel_row,
  output logic [N-1:0]       deq_row,
  output logic               busy
);

  logic             conn_q, conn_d;
  logic [N-1:0]     col_q, col_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] raw_len;
  logic [LEN_W-1:0] load_len;
  logic             fire;

  always_comb begin
    raw_len = '0;
    for (int j = 0; j < N; j++) begin
      if (grant_row[j]) begin
        raw_len = raw_len | len_row[j*LEN_W +: LEN_W];
      end
    end
  end

  // A zero-length head still carries one flit.
  assign load_len = (raw_len == '0) ? LEN_W'(1) : raw_len;

  assign sel_row = col_q;
  assign deq_row = conn_q ? (col_q & out_ready) : '0;
  assign fire    = |deq_row;
  assign busy    = conn_q;

  always_comb begin
    conn_d = conn_q;
    col_d  = col_q;
    cnt_d  = cnt_q;
    if (conn_q) begin
      if (fire) begin
        if (cnt_q == LEN_W'(1)) begin
          conn_d = 1'b0;
          col_d  = '0;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
    end else if (|grant_row) begin
      conn_d = 1'b1;
      col_d  = grant_row;
      cnt_d  = load_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conn_q <= 1'b0;
      col_q  <= '0;
      cnt_q  <= '0;
    end else begin
      conn_q <= conn_d;
      col_q  <= col_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/xbar_sched.sv
// Front/back end around the external 4x4 arbiter array: request
// masking, grant sanitising and per-row connection slots.
module xbar_sched
  import xbar_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*N-1:0]         voq_req,
  input  logic [N*N*LEN_W-1:0]   voq_len,
  input  logic [N-1:0]           out_ready,
  output logic [N*N-1:0]         arb_req,
  input  logic [N*N-1:0]         arb_grant,
  output logic [N*N-1:0]         xbar_sel,
  output logic [N*N-1:0]         deq,
  output logic [N-1:0]           in_busy,
  output logic [N-1:0]           out_busy,
  output logic                   err
);

  logic [N*N-1:0] san;
  logic [N*N-1:0] grant_v;
  logic [N-1:0]   row_v;
  logic [N-1:0]   col_v;
  logic           bad;
  logic           err_q, err_d;

  // Busy state is registered only, so arb_grant never loops back.
  always_comb begin
    arb_req = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        arb_req[idx(i, j)] = voq_req[idx(i, j)] & ~in_busy[i]
                           & ~out_busy[j];
      end
    end
  end

  assign san = arb_grant & arb_req;

  always_comb begin
    bad   = 1'b0;
    row_v = '0;
    col_v = '0;
    for (int i = 0; i < N; i++) begin
      row_v = san[i*N +: N];
      if (!onehot_ok(row_v)) bad = 1'b1;
    end
    for (int j = 0; j < N; j++) begin
      col_v = '0;
      for (int i = 0; i < N; i++) begin
        col_v[i] = san[idx(i, j)];
      end
      if (!onehot_ok(col_v)) bad = 1'b1;
    end
  end

  assign grant_v = bad ? '0 : san;
  assign err_d   = err_q | bad;
  assign err     = err_q;

  always_comb begin
    out_busy = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        out_busy[j] = out_busy[j] | xbar_sel[idx(i, j)];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    conn_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .grant_row (grant_v[gi*N +: N]),
      .len_row   (voq_len[gi*N*LEN_W +: N*LEN_W]),
      .out_ready (out_ready),
      .sel_row   (xbar_sel[gi*N +: N]),
      .deq_row   (deq[gi*N +: N]),
      .busy      (in_busy[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_xbar_sched.sv
// Bench for xbar_sched: directed plan scenarios plus random traffic,
// all checked against a per-row packet model.
module tb_xbar_sched;

  logic        clk;
  logic        rst;
  logic [15:0] voq_req;
  logic [63:0] voq_len;
  logic [3:0]  out_ready;
  logic [15:0] arb_req;
  logic [15:0] arb_grant;
  logic [15:0] xbar_sel;
  logic [15:0] deq;
  logic [3:0]  in_busy;
  logic [3:0]  out_busy;
  logic        err;

  int tests;
  int fails;

  bit m_act[4];
  int m_tgt[4];
  int m_rem[4];
  bit m_err;

  xbar_sched dut (
    .clk       (clk),
    .rst       (rst),
    .voq_req   (voq_req),
    .voq_len   (voq_len),
    .out_ready (out_ready),
    .arb_req   (arb_req),
    .arb_grant (arb_grant),
    .xbar_sel  (xbar_sel),
    .deq       (deq),
    .in_busy   (in_busy),
    .out_busy  (out_busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 1'b0;
      m_tgt[i] = 0;
      m_rem[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic bit col_taken(input int j);
    for (int k = 0; k < 4; k++)
      if (m_act[k] && m_tgt[k] == j) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] e_req();
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[i*4+j] = voq_req[i*4+j] && !m_act[i] && !col_taken(j);
    return r;
  endfunction

  function automatic logic [15:0] e_sel();
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (m_act[i]) r[i*4+m_tgt[i]] = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] e_deq();
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (m_act[i] && out_ready[m_tgt[i]]) r[i*4+m_tgt[i]] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] e_inb();
    logic [3:0] r = '0;
    for (int i = 0; i < 4; i++) r[i] = m_act[i];
    return r;
  endfunction

  function automatic logic [3:0] e_outb();
    logic [3:0] r = '0;
    for (int j = 0; j < 4; j++) r[j] = col_taken(j);
    return r;
  endfunction

  task automatic settle();
    #1;
    chk("arb_req", 32'(arb_req), 32'(e_req()));
    chk("xbar_sel", 32'(xbar_sel), 32'(e_sel()));
    chk("deq", 32'(deq), 32'(e_deq()));
    chk("in_busy", 32'(in_busy), 32'(e_inb()));
    chk("out_busy", 32'(out_busy), 32'(e_outb()));
    chk("err", 32'(err), 32'(m_err));
  endtask

  // Apply one clock edge to the model using the inputs held this cycle.
  task automatic advance();
    logic [15:0] req;
    logic [15:0] g;
    int rc[4];
    int cc[4];
    bit legal;
    int l;
    req = e_req();
    g = arb_grant & req;
    @(posedge clk);
    legal = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rc[k] = 0;
      cc[k] = 0;
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (g[i*4+j]) begin
          rc[i]++;
          cc[j]++;
        end
    for (int k = 0; k < 4; k++)
      if (rc[k] > 1 || cc[k] > 1) legal = 1'b0;
    for (int i = 0; i < 4; i++)
      if (m_act[i] && out_ready[m_tgt[i]]) begin
        m_rem[i]--;
        if (m_rem[i] == 0) m_act[i] = 1'b0;
      end
    if (!legal) m_err = 1'b1;
    else
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (g[i*4+j]) begin
            l = int'(voq_len[(i*4+j)*4 +: 4]);
            m_act[i] = 1'b1;
            m_tgt[i] = j;
            m_rem[i] = (l == 0) ? 1 : l;
          end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic gen_grant(output logic [15:0] g);
    logic [15:0] r;
    logic [3:0] used;
    int s;
    int j;
    bit done;
    r = e_req();
    g = '0;
    used = '0;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        s = $urandom_range(0, 3);
        done = 1'b0;
        for (int k = 0; k < 4; k++) begin
          j = (s + k) % 4;
          if (!done && r[i*4+j] && !used[j]) begin
            g[i*4+j] = 1'b1;
            used[j] = 1'b1;
            done = 1'b1;
          end
        end
      end
    end
    if ($urandom_range(0, 4) == 0) g = g | (16'($urandom) & ~r);
    if ($urandom_range(0, 79) == 0) g = 16'($urandom);
  endtask

  initial begin
    logic [15:0] g;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    voq_req = '0;
    voq_len = '0;
    out_ready = 4'hF;
    arb_grant = '0;
    m_reset();
    #2;
    chk("reset_sel", 32'(xbar_sel), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    settle();

    // Single grant on (1,1), len 3.
    voq_req = 16'h0020;
    voq_len = '0;
    voq_len[5*4 +: 4] = 4'd3;
    arb_grant = 16'h0020;
    step();
    arb_grant = '0;
    settle();
    chk("single_sel", 32'(xbar_sel), 32'h0020);
    chk("single_inb", 32'(in_busy), 32'h2);
    advance();
    step();
    step();
    settle();
    chk("single_rereq", 32'(arb_req), 32'h0020);
    chk("single_free", 32'(xbar_sel), 32'h0);
    advance();

    // Stall on out_ready[1] in the second transfer cycle.
    voq_req = '0;
    step();
    voq_req = 16'h0020;
    arb_grant = 16'h0020;
    step();
    arb_grant = '0;
    step();
    out_ready = 4'hD;
    settle();
    chk("stall_deq", 32'(deq), 32'h0);
    advance();
    out_ready = 4'hF;
    step();
    settle();
    chk("stall_last", 32'(deq), 32'h0020);
    advance();
    settle();
    chk("stall_rel", 32'(xbar_sel), 32'h0);
    voq_req = '0;
    advance();

    // Contention masking around (0,2).
    voq_req = 16'h0004;
    voq_len[2*4 +: 4] = 4'd4;
    arb_grant = 16'h0004;
    step();
    arb_grant = '0;
    voq_req = 16'h0044;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("mask_2_6", 32'(arb_req & 16'h0044), 32'h0);
      advance();
    end
    step();

    // Parallel permutation, len 1 each.
    voq_req = 16'h8421;
    voq_len = {16{4'h1}};
    arb_grant = 16'h8421;
    step();
    arb_grant = '0;
    settle();
    chk("perm_sel", 32'(xbar_sel), 32'h8421);
    chk("perm_deq", 32'(deq), 32'h8421);
    advance();
    settle();
    chk("perm_busy", 32'({in_busy, out_busy}), 32'h0);
    advance();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      voq_req = 16'($urandom) | 16'($urandom);
      voq_len = {$urandom, $urandom};
      out_ready = 4'($urandom) | 4'($urandom);
      gen_grant(g);
      arb_grant = g;
      step();
    end

    // Illegal same-row grant.
    arb_grant = '0;
    do_reset();
    voq_req = 16'h0003;
    voq_len = {16{4'h2}};
    out_ready = 4'hF;
    arb_grant = 16'h0003;
    step();
    arb_grant = '0;
    settle();
    chk("illegal_err", 32'(err), 32'h1);
    chk("illegal_sel", 32'(xbar_sel), 32'h0);
    advance();
    for (int c = 0; c < 3; c++) step();

    // Asynchronous reset during a len 8 transfer on (1,2).
    do_reset();
    voq_req = 16'h0040;
    voq_len = '0;
    voq_len[6*4 +: 4] = 4'd8;
    arb_grant = 16'h0040;
    step();
    arb_grant = '0;
    for (int c = 0; c < 3; c++) step();
    settle();
    rst = 1'b1;
    m_reset();
    #1;
    chk("arst_sel", 32'(xbar_sel), 32'h0);
    chk("arst_deq", 32'(deq), 32'h0);
    chk("arst_busy", 32'({in_busy, out_busy}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    settle();
    chk("arst_req", 32'(arb_req), 32'h0040);
    advance();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xbar_sched.md
Name: xbar_sched

Overview:
- Sequential front/back end for the 4x4 rectilinear arbiter array.
- Builds the 16-bit request matrix from the input virtual-output-queue (VOQ) heads and drives it into the array.
- Captures the array's grant and holds each crossbar connection for the full length of a multi-flit packet.
- Generates per-flit dequeue strobes and the crossbar select matrix; the arbiter itself stays outside this block.

Parameters:
- N, 4, ports per side; the matrix is N*N, index = in*N + out.
- LEN_W, 4, width of the packet length field in flits.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- voq_req  input  N*N  bit in*N+out set: input `in` has a head packet for output `out`.
- voq_len  input  N*N*LEN_W  head packet length per VOQ, same index order.
- out_ready  input  N  output `out` accepts a flit this cycle.
- arb_req  output  N*N  masked request matrix to the arbiter array (combinational).
- arb_grant  input  N*N  grant matrix from the arbiter array (combinational return, same cycle).
- xbar_sel  output  N*N  registered connection matrix; at most one bit per row and per column.
- deq  output  N*N  one-cycle flit dequeue strobe per VOQ.
- in_busy  output  N  input row currently holds a connection.
- out_busy  output  N  output column currently holds a connection.
- err  output  1  sticky: an illegal grant was seen.

Behaviour:
- Reset values (asynchronous): xbar_sel=0, deq=0, in_busy=0, out_busy=0, err=0, all length counters=0.
- Masking: arb_req[i*N+j] = voq_req[i*N+j] & ~in_busy[i] & ~out_busy[j]. Masking uses registered state only, so there is no combinational loop through arb_grant.
- Grant sanitising, at cycle t, for grant bits with arb_req=1:
  - Bits where arb_req=0 are ignored.
  - If more than one sanitised bit is set in any row or any column, the whole grant is discarded for that cycle and err is set.
- Connect, on a valid grant (i,j) at cycle t:
  - At edge t+1: xbar_sel[i*N+j]=1, in_busy[i]=1, out_busy[j]=1.
  - cnt[i] loads voq_len of (i,j); a length of 0 is treated as 1.
- Transfer, from cycle t+1 while the connection is active:
  - deq[i*N+j] = out_ready[j] (combinational from the registered state).
  - cnt[i] decrements on each cycle with deq=1.
  - out_ready=0 stalls the transfer; the counter holds.
- Release: on the cycle that deq fires with cnt[i]==1, the connection clears at the next edge (xbar_sel bit, in_busy, out_busy, cnt all go to 0).
- Bubble: released resources become requestable the cycle after release, so back-to-back packets on the same row or column have a one-cycle gap. Minimum grant-to-regrant spacing is len+1 cycles.
- Simultaneous events:
  - A release on row i and a grant on a different row for the same freed column cannot coincide, because the column is masked until release.
  - Independent rows/columns connect and release in the same cycle with no interaction.
- voq_req dropping while a connection is active: ignored. The connection completes its counted length, and the producer is required to hold the packet.
- Reset mid-packet: all connections drop immediately and deq goes to 0. Partially sent packets are the producer's responsibility.
- err is cleared only by rst.

Decomposition:
- Package xbar_pkg holds:
  - Constants N and LEN_W.
  - Function idx(in,out) = in*N+out.
  - Function onehot_ok(vector), used for the row/column legality check.
- Sub-module conn_slot, one instance per input row, holds that row's state and logic:
  - State: connected flag, target column (one-hot), cnt.
  - Logic: the load/decrement/release rules.
  - Outputs: its xbar_sel row and deq row.
- The top level does masking, grant sanitising, the column OR for out_busy, and err.

Test Plan:
- Single grant: voq_req bit 5 (in1,out1), len=3, out_ready=1111, arbiter grants bit 5 at t -> xbar_sel=0x0020 for t+1..t+3, deq bit 5 pulses 3 cycles, in_busy=0010 during the transfer, release at t+4, arb_req bit 5 reasserts at t+4.
- Stall: same as above but out_ready[1]=0 at t+2 -> deq pulses at t+1, t+3, t+4; release after t+4.
- Contention masking: input 0 connected to out2 (len 4); voq_req bits 2 and 6 set -> arb_req bits 2 and 6 both 0 until release.
- Parallel permutation: grant bits 0, 5, 10, 15 together, len=1 each -> xbar_sel=0x8421 for one cycle, four deq pulses, all busy bits clear at the next edge.
- Illegal grant: arbiter returns bits 0 and 1 (same row) -> no connection forms, err=1 and stays 1 until rst.
- Async reset mid-packet: rst asserted between edges during a len=8 transfer -> xbar_sel, deq and busy go to 0 immediately; after reset, voq_req produces arb_req normally.
